// File: rtl/pim_cmd_receiver.sv
// Host command receiver for the PIM matmul top: synchronises the start strobe,
// queues {src1,src2,dst} commands and dispatches them one at a time to the engine.
module pim_cmd_receiver #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        src1_addr,
  input  logic [ADDR_W-1:0]        src2_addr,
  input  logic [ADDR_W-1:0]        dst_addr,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [ADDR_W-1:0]        cmd_src1,
  output logic [ADDR_W-1:0]        cmd_src2,
  output logic [ADDR_W-1:0]        cmd_dst,
  input  logic                     eng_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         done_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     proto_err,
  output logic [1:0]               fsm_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Engine handshake: a command transfers on a cycle where cmd_valid and
  // cmd_ready are both high; cmd_valid never falls and cmd_* never change
  // before that transfer.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_DONE = 2'd2} state_t;

  state_t state, state_nxt;

  logic s1, s2, s3;
  logic push, pop, full, empty, push_ok, drop;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [ADDR_W-1:0] mem_src1 [DEPTH];
  logic [ADDR_W-1:0] mem_src2 [DEPTH];
  logic [ADDR_W-1:0] mem_dst  [DEPTH];

  // s1/s2 form the metastability synchroniser; s3 gives a one-cycle rising-edge push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= start;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign push    = s2 & ~s3;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop     = (state == IDLE) & ~empty;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_src1[wr_ptr] <= src1_addr;
      mem_src2[wr_ptr] <= src2_addr;
      mem_dst[wr_ptr]  <= dst_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!empty) state_nxt = ISSUE;
      ISSUE:     if (cmd_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (eng_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_src1  <= '0;
      cmd_src2  <= '0;
      cmd_dst   <= '0;
      done_cnt  <= '0;
      drop_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (pop) begin
        cmd_src1 <= mem_src1[rd_ptr];
        cmd_src2 <= mem_src2[rd_ptr];
        cmd_dst  <= mem_dst[rd_ptr];
      end
      if (drop && (drop_cnt != {CNT_W{1'b1}})) drop_cnt <= drop_cnt + CNT_W'(1);
      if (eng_done) begin
        if (state == WAIT_DONE) done_cnt <= done_cnt + CNT_W'(1);
        else                    proto_err <= 1'b1;
      end
    end
  end

  assign cmd_valid  = (state == ISSUE);
  assign fifo_count = count;
  assign busy       = ~empty | (state != IDLE);
  assign fsm_state  = state;

endmodule

// File: tb/tb_pim_cmd_receiver.sv
// Directed bench for pim_cmd_receiver: queued expected commands are compared
// against every engine handshake, plus counter/flag checks at key points.
module tb_pim_cmd_receiver;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;
  localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2;

  logic clk, rst, start, cmd_ready, eng_done;
  logic [ADDR_W-1:0] src1_addr, src2_addr, dst_addr;
  logic cmd_valid, busy, proto_err;
  logic [ADDR_W-1:0] cmd_src1, cmd_src2, cmd_dst;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNT_W-1:0] done_cnt, drop_cnt;
  logic [1:0] fsm_state;

  logic [3*ADDR_W-1:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int n_disp   = 0;
  int n_valid  = 0;

  pim_cmd_receiver #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src1_addr(src1_addr), .src2_addr(src2_addr), .dst_addr(dst_addr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
    .eng_done(eng_done), .busy(busy), .fifo_count(fifo_count),
    .done_cnt(done_cnt), .drop_cnt(drop_cnt), .proto_err(proto_err),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every transfer on the engine handshake pops one expected command
  always @(negedge clk) begin
    if (rst && cmd_valid) n_valid++;
    if (rst && cmd_valid && cmd_ready) begin
      n_disp++;
      if (exp_q.size() == 0) chk("unexpected_dispatch", 1, 0);
      else chk("dispatch", {cmd_src1, cmd_src2, cmd_dst}, exp_q.pop_front());
    end
  end

  // driver tasks (called at posedge+1)
  task automatic pulse(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                       input logic [ADDR_W-1:0] d, input int len, input int gap,
                       input bit accept);
    src1_addr = a; src2_addr = b; dst_addr = d;
    start = 1'b1;
    if (accept) exp_q.push_back({a, b, d});
    repeat (len) @(posedge clk);
    #1 start = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic done_pulse();
    eng_done = 1'b1;
    @(posedge clk);
    #1 eng_done = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [1:0] target, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (fsm_state == target) break;
    end
    chk(tag, fsm_state, target);
  endtask

  initial begin
    int d0, v0;
    logic [ADDR_W-1:0] ra, rb, rd;
    rst = 1'b0; start = 1'b0; cmd_ready = 1'b0; eng_done = 1'b0;
    src1_addr = '0; src2_addr = '0; dst_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {cmd_valid, busy, proto_err, fifo_count, done_cnt, drop_cnt,
                        cmd_src1, cmd_src2, cmd_dst}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: reset mid-ISSUE with two commands queued
    pulse(32'h11, 32'h12, 32'h13, 2, 4, 1'b1);
    pulse(32'h21, 32'h22, 32'h23, 2, 4, 1'b1);
    pulse(32'h31, 32'h32, 32'h33, 2, 4, 1'b1);
    chk("t1_issue", fsm_state, S_ISSUE);
    chk("t1_count", fifo_count, 2);
    rst = 1'b0;
    #1;
    chk("t1_rst_outputs", {cmd_valid, busy, proto_err, fifo_count, done_cnt, drop_cnt,
                           cmd_src1, cmd_src2, cmd_dst}, 0);
    chk("t1_rst_state", fsm_state, S_IDLE);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("t1_after_rst_count", fifo_count, 0);

    // 2: single command, start held 10 cycles, push latency 3 edges
    cmd_ready = 1'b1;
    v0 = n_valid; d0 = n_disp;
    src1_addr = 32'h100; src2_addr = 32'h200; dst_addr = 32'h300;
    start = 1'b1;
    exp_q.push_back({32'h100, 32'h200, 32'h300});
    repeat (2) @(posedge clk);
    #1 chk("t2_count_e2", fifo_count, 0);
    @(posedge clk);
    #1 chk("t2_count_e3", fifo_count, 1);
    chk("t2_busy", busy, 1);
    repeat (7) @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("t2_wait", fsm_state, S_WAIT);
    done_pulse();
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_busy_off", busy, 0);
    chk("t2_valid_cycles", n_valid - v0, 1);
    chk("t2_disp", n_disp - d0, 1);

    // 3: overflow with engine stalled, then drain in order
    cmd_ready = 1'b0;
    for (int k = 0; k < 6; k++)
      pulse(32'h1000 + k, 32'h2000 + k, 32'h3000 + k, 2, 4, k < 5);
    chk("t3_issue", fsm_state, S_ISSUE);
    chk("t3_count", fifo_count, 4);
    chk("t3_drop", drop_cnt, 1);
    cmd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_state("t3_wait", S_WAIT, 20);
      done_pulse();
    end
    chk("t3_done_cnt", done_cnt, 6);
    chk("t3_q_empty", exp_q.size(), 0);
    chk("t3_busy_off", busy, 0);

    // 4: backpressure for 20 cycles
    cmd_ready = 1'b0;
    ra = $urandom; rb = $urandom; rd = $urandom;
    pulse(ra, rb, rd, 2, 4, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t4_stable", {cmd_valid, cmd_src1, cmd_src2, cmd_dst}, {1'b1, ra, rb, rd});
    end
    @(posedge clk);
    #1 cmd_ready = 1'b1;
    wait_state("t4_wait", S_WAIT, 10);
    done_pulse();
    chk("t4_done_cnt", done_cnt, 7);

    // 5: eng_done while IDLE
    chk("t5_perr_before", proto_err, 0);
    done_pulse();
    chk("t5_perr", proto_err, 1);
    chk("t5_done_cnt", done_cnt, 7);
    repeat (5) @(posedge clk);
    #1 chk("t5_perr_sticky", proto_err, 1);

    // 6: long start gives one push; flood saturates drop_cnt
    d0 = n_disp;
    pulse(32'hAAA0, 32'hBBB0, 32'hCCC0, 200, 4, 1'b1);
    wait_state("t6_wait", S_WAIT, 10);
    done_pulse();
    chk("t6_one_push", n_disp - d0, 1);
    chk("t6_count", fifo_count, 0);
    chk("t6_drop_before", drop_cnt, 1);
    cmd_ready = 1'b0;
    for (int k = 0; k < 262; k++) begin
      pulse($urandom, $urandom, ADDR_W'($urandom_range(0, 32'hFFFF)), 1, 3, k < 5);
      if (k == 257) chk("t6_drop_254", drop_cnt, 254);
      if (k == 258) chk("t6_drop_255", drop_cnt, 255);
    end
    chk("t6_drop_sat", drop_cnt, 255);
    chk("t6_count_full", fifo_count, 4);
    cmd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_state("t6_wait_drain", S_WAIT, 20);
      done_pulse();
    end
    chk("t6_done_cnt", done_cnt, 13);
    chk("t6_q_empty", exp_q.size(), 0);
    chk("t6_perr_sticky", proto_err, 1);
    chk("t6_busy_off", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
